hex_word_encoder: RTL

HEX_WORD_ENCODER -- requirements
Module: hex_word_encoder

---
 rtl/hex_word_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hex_word_encoder.sv
// hex_word_encoder
// Turns one binary word into its ASCII hex digits, most significant digit
// first, with an optional CR/LF trailer. A valid/ready handshake is used on
// both sides. Leading zeros are always emitted, so every word produces exactly
// DATA_WIDTH/4 digits. DATA_WIDTH must be a multiple of 4 in the range 4..64.

module hex_word_encoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int UPPERCASE   = 1,
  parameter int APPEND_CRLF = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_char,
  output logic                  out_last,
  output logic                  busy
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Adding the nibble value (10..15) to this base lands on 'A'/'a'..'F'/'f'.
  localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h37 : 8'h57;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    CR     = 2'd2,
    LF     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  // Holds in_ready low until the first clock edge after reset is released.
  logic                    ready_en_q;

  logic [3:0]              top_nib;
  logic [7:0]              hex_char;

  assign top_nib = data_q[DATA_WIDTH-1 -: 4];

  // ASCII conversion of the most significant remaining nibble.
  always_comb begin
    hex_char = 8'h00;
    if (top_nib < 4'd10) begin
      hex_char = 8'h30 + {4'h0, top_nib};
    end else begin
      hex_char = ALPHA_BASE + {4'h0, top_nib};
    end
  end

  // State, shift register and nibble counter; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic: every output handshake advances by exactly one character.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          cnt_d   = CNT_W'(NIBBLES - 1);
          state_d = DIGITS;
        end
      end
      DIGITS: begin
        if (out_ready) begin
          data_d = data_q << 4;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = (APPEND_CRLF != 0) ? CR : IDLE;
          end
        end
      end
      CR: begin
        if (out_ready) begin
          state_d = LF;
        end
      end
      LF: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded purely from registered state, so they stay stable
  // while the downstream stalls.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_char  = 8'h00;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ready_en_q;
      end
      DIGITS: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = hex_char;
        out_last  = (cnt_q == '0) && (APPEND_CRLF == 0);
      end
      CR: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = 8'h0D;
      end
      LF: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_char  = 8'h0A;
        out_last  = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
